sprite_layer_engine: RTL

Multi-sprite successor to the single-tile pizza position/draw block. Holds NUM_SPRITES double-buffered sprite positions and enables. For each (hcount, vcount) it picks the highest-priority sprite covering the pixel and fetches its texel from an external synchronous sprite ROM, using a global animation frame. It sits between the VGA sync counter and the colour mux, and emits a registered pixel code with a fixed pipeline latency.

---
 rtl/sprite_layer_engine.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sprite_layer_engine.sv
// rtl/sprite_layer_engine.sv - multi-sprite hit test, ROM fetch and pixel output pipeline
module sprite_layer_engine #(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int COORD_W     = 10,
  parameter int PIX_W       = 2,
  parameter int ANIM_FRAMES = 4,
  parameter int ANIM_DIV    = 8,
  localparam int ID_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int FR_W  = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1,
  localparam int X_W   = (SPR_W > 1) ? $clog2(SPR_W) : 1,
  localparam int Y_W   = (SPR_H > 1) ? $clog2(SPR_H) : 1,
  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic               bounds_draw,
  input  logic               frame_start,
  input  logic               pos_we,
  input  logic [ID_W-1:0]    pos_sel,
  input  logic [COORD_W-1:0] pos_h,
  input  logic [COORD_W-1:0] pos_v,
  input  logic               pos_en,
  output logic [ID_W-1:0]    mem_id,
  output logic [FR_W-1:0]    mem_frame,
  output logic [X_W-1:0]     mem_x,
  output logic [Y_W-1:0]     mem_y,
  input  logic [PIX_W-1:0]   mem_data,
  output logic [PIX_W-1:0]   pix_out,
  output logic               pix_hit,
  output logic [ID_W-1:0]    hit_id
);

  logic [COORD_W-1:0] r_pend_h  [NUM_SPRITES];
  logic [COORD_W-1:0] r_pend_v  [NUM_SPRITES];
  logic               r_pend_en [NUM_SPRITES];
  logic [COORD_W-1:0] r_act_h   [NUM_SPRITES];
  logic [COORD_W-1:0] r_act_v   [NUM_SPRITES];
  logic               r_act_en  [NUM_SPRITES];
  logic [DIV_W-1:0]   r_div;
  logic [FR_W-1:0]    r_frame;

  logic               r_hit1;
  logic [ID_W-1:0]    r_mem_id;
  logic [FR_W-1:0]    r_mem_frame;
  logic [X_W-1:0]     r_mem_x;
  logic [Y_W-1:0]     r_mem_y;
  logic               r_hit2;
  logic [ID_W-1:0]    r_id2;

  logic [NUM_SPRITES-1:0] w_cover;
  logic                   w_hit;
  logic [ID_W-1:0]        w_idx;
  logic [X_W-1:0]         w_dx;
  logic [Y_W-1:0]         w_dy;

  // Copy reads the pre-edge pending values, so a same-cycle write waits one frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_pend_h[i]  <= '0;
        r_pend_v[i]  <= '0;
        r_pend_en[i] <= 1'b0;
        r_act_h[i]   <= '0;
        r_act_v[i]   <= '0;
        r_act_en[i]  <= 1'b0;
      end
      r_div   <= '0;
      r_frame <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (frame_start) begin
          r_act_h[i]  <= r_pend_h[i];
          r_act_v[i]  <= r_pend_v[i];
          r_act_en[i] <= r_pend_en[i];
        end
        if (pos_we && (pos_sel == ID_W'(i))) begin
          r_pend_h[i]  <= pos_h;
          r_pend_v[i]  <= pos_v;
          r_pend_en[i] <= pos_en;
        end
      end
      if (frame_start) begin
        if (r_div == DIV_W'(ANIM_DIV - 1)) begin
          r_div   <= '0;
          r_frame <= (r_frame == FR_W'(ANIM_FRAMES - 1)) ? '0 : r_frame + 1'b1;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  // Right/bottom extents are one bit wider so edge sprites clip instead of wrapping.
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_cover
    logic [COORD_W:0] w_h_end;
    logic [COORD_W:0] w_v_end;
    assign w_h_end = {1'b0, r_act_h[g]} + (COORD_W+1)'(SPR_W);
    assign w_v_end = {1'b0, r_act_v[g]} + (COORD_W+1)'(SPR_H);
    assign w_cover[g] = r_act_en[g] && bounds_draw &&
                        (hcount >= r_act_h[g]) && ({1'b0, hcount} < w_h_end) &&
                        (vcount >= r_act_v[g]) && ({1'b0, vcount} < w_v_end);
  end

  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    w_dx  = '0;
    w_dy  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_cover[i]) begin
        w_hit = 1'b1;
        w_idx = ID_W'(i);
        w_dx  = X_W'(hcount - r_act_h[i]);
        w_dy  = Y_W'(vcount - r_act_v[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit1      <= 1'b0;
      r_mem_id    <= '0;
      r_mem_frame <= '0;
      r_mem_x     <= '0;
      r_mem_y     <= '0;
      r_hit2      <= 1'b0;
      r_id2       <= '0;
    end else begin
      r_hit1      <= w_hit;
      r_mem_id    <= w_hit ? w_idx   : '0;
      r_mem_frame <= w_hit ? r_frame : '0;
      r_mem_x     <= w_hit ? w_dx    : '0;
      r_mem_y     <= w_hit ? w_dy    : '0;
      r_hit2      <= r_hit1;
      r_id2       <= r_mem_id;
    end
  end

  assign mem_id    = r_mem_id;
  assign mem_frame = r_mem_frame;
  assign mem_x     = r_mem_x;
  assign mem_y     = r_mem_y;
  // The ROM register is the second pipeline stage; only the qualifying gate follows it.
  assign pix_out   = r_hit2 ? mem_data : '0;
  assign pix_hit   = r_hit2 && (mem_data != '0);
  assign hit_id    = r_id2;

endmodule
